// File: rtl/queue_sensor_frontend.sv
// queue_sensor_frontend: sync, debounce and serialize two door sensors
// into step/updown commands. Define QSF_STATS_EN for the arrivals counter.
module queue_sensor_frontend #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enter_raw,
    input  logic        leave_raw,
    output logic        step,
    output logic        updown,
    output logic        ev_drop
`ifdef QSF_STATS_EN
    ,
    output logic [15:0] arrivals
`endif
);

    // Channel 0 is the entrance (up), channel 1 the exit (down).
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    logic [1:0]      raw;
    logic [1:0]      sync1;
    logic [1:0]      s;
    logic [1:0]      db;
    logic [1:0]      db_q;
    logic [DB_W-1:0] cnt [2];
    logic [1:0]      req;
    logic [1:0]      pend;
    logic [1:0]      clr;
    state_t          state;
    state_t          state_d;
    logic            step_d;
    logic            updown_d;

    assign raw = {leave_raw, enter_raw};
    assign req = db & ~db_q;

    // Two-flop synchronizer for the asynchronous sensor inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
        end
    end

    // Debounce filter: accept a change only after it persists long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db     <= '0;
            db_q   <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            db_q <= db;
            for (int i = 0; i < 2; i++) begin
                if (s[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    db[i]  <= s[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Pending flags; a new request beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend    <= '0;
            ev_drop <= 1'b0;
        end else begin
            pend    <= req | (pend & ~clr);
            ev_drop <= |(req & pend & ~clr);
        end
    end

    // Command FSM state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step   <= 1'b0;
            updown <= 1'b0;
        end else begin
            state  <= state_d;
            step   <= step_d;
            updown <= updown_d;
        end
    end

    // Next-state logic: up has priority, then a two-cycle spacing.
    always_comb begin
        state_d  = state;
        step_d   = 1'b0;
        updown_d = updown;
        clr      = 2'b00;
        case (state)
            IDLE: begin
                if (pend[0]) begin
                    step_d   = 1'b1;
                    updown_d = 1'b1;
                    clr      = 2'b01;
                    state_d  = PULSE;
                end else if (pend[1]) begin
                    step_d   = 1'b1;
                    updown_d = 1'b0;
                    clr      = 2'b10;
                    state_d  = PULSE;
                end
            end
            PULSE:   state_d = GAP;
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef QSF_STATS_EN
    // Count issued increment commands, wrapping at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arrivals <= '0;
        end else if (step_d && updown_d) begin
            arrivals <= arrivals + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_queue_sensor_frontend.sv
// tb_queue_sensor_frontend: directed stimulus with a cycle model of the
// debounce/command rules and per-cycle output comparison.
module tb_queue_sensor_frontend;

    localparam int D = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enter_raw = 1'b0;
    logic leave_raw = 1'b0;
    logic step;
    logic updown;
    logic ev_drop;
`ifdef QSF_STATS_EN
    logic [15:0] arrivals;
`endif

    queue_sensor_frontend #(
        .DEBOUNCE_CYCLES(D),
        .DB_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enter_raw(enter_raw),
        .leave_raw(leave_raw),
        .step(step),
        .updown(updown),
        .ev_drop(ev_drop)
`ifdef QSF_STATS_EN
        ,
        .arrivals(arrivals)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;
    int t0 = 0;
    int nsteps = 0;
    int ndrops = 0;
    int log_rel [8];
    int log_ud [8];

    // Model state: channel 0 entrance, channel 1 exit.
    bit sy1 [2];
    bit sy2 [2];
    bit dbm [2];
    bit dbq [2];
    bit pend [2];
    int streak [2];
    int since = 3;
    bit exp_step = 0;
    bit exp_updown = 0;
    bit exp_drop = 0;
    logic [15:0] exp_arr = 16'h0000;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Edge counter used to time commands relative to a stimulus start.
    always @(posedge clk) edge_no++;

    // Behavioural model: s lags raw by two edges; db flips after D
    // consecutive disagreeing samples; commands at least 3 edges apart.
    always @(posedge clk or posedge reset) begin : model
        bit raw [2];
        bit req [2];
        int issue;
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                sy1[c] = 0; sy2[c] = 0; dbm[c] = 0;
                dbq[c] = 0; pend[c] = 0; streak[c] = 0;
            end
            since = 3;
            exp_step = 0;
            exp_updown = 0;
            exp_drop = 0;
            exp_arr = 16'h0000;
        end else begin
            raw[0] = enter_raw;
            raw[1] = leave_raw;
            for (int c = 0; c < 2; c++) begin
                req[c] = dbm[c] && !dbq[c];
                dbq[c] = dbm[c];
                if (sy2[c] != dbm[c]) begin
                    streak[c]++;
                    if (streak[c] == D) begin
                        dbm[c] = sy2[c];
                        streak[c] = 0;
                    end
                end else begin
                    streak[c] = 0;
                end
                sy2[c] = sy1[c];
                sy1[c] = raw[c];
            end
            issue = -1;
            if (since >= 3) begin
                if (pend[0]) issue = 0;
                else if (pend[1]) issue = 1;
            end
            exp_step = (issue >= 0);
            if (issue >= 0) begin
                exp_updown = (issue == 0);
                since = 1;
                if (issue == 0) exp_arr = exp_arr + 16'd1;
            end else if (since < 3) begin
                since++;
            end
            exp_drop = 0;
            for (int c = 0; c < 2; c++) begin
                if (req[c]) begin
                    if (pend[c] && issue != c) exp_drop = 1;
                    pend[c] = 1;
                end else if (issue == c) begin
                    pend[c] = 0;
                end
            end
        end
    end

    // Compare every cycle and log command pulses for the directed checks.
    always @(negedge clk) begin
        chk("step", int'(step), int'(exp_step));
        chk("updown", int'(updown), int'(exp_updown));
        chk("ev_drop", int'(ev_drop), int'(exp_drop));
`ifdef QSF_STATS_EN
        chk("arrivals", int'(arrivals), int'(exp_arr));
`endif
        if (step) begin
            if (nsteps < 8) begin
                log_rel[nsteps] = edge_no - 1 - t0;
                log_ud[nsteps] = int'(updown);
            end
            nsteps++;
        end
        if (ev_drop) ndrops++;
    end

    initial begin
        reset = 1'b1;
        cyc(3);
        chk("rst_step", int'(step), 0);
        chk("rst_updown", int'(updown), 0);
        chk("rst_drop", int'(ev_drop), 0);
        reset = 1'b0;
        cyc(2);

        // Held entrance: one up command after edge 7.
        enter_raw = 1'b1; t0 = edge_no; nsteps = 0; ndrops = 0;
        cyc(20);
        chk("t1_steps", nsteps, 1);
        chk("t1_edge", log_rel[0], 7);
        chk("t1_ud", log_ud[0], 1);
        enter_raw = 1'b0;
        cyc(12);

        // Short glitch: filtered out.
        enter_raw = 1'b1; nsteps = 0; ndrops = 0;
        cyc(3);
        enter_raw = 1'b0;
        cyc(15);
        chk("t2_steps", nsteps, 0);
        chk("t2_drops", ndrops, 0);

        // Simultaneous entrance and exit.
        enter_raw = 1'b1; leave_raw = 1'b1;
        t0 = edge_no; nsteps = 0; ndrops = 0;
        cyc(20);
        chk("t3_steps", nsteps, 2);
        chk("t3_edge0", log_rel[0], 7);
        chk("t3_ud0", log_ud[0], 1);
        chk("t3_edge1", log_rel[1], 10);
        chk("t3_ud1", log_ud[1], 0);
        chk("t3_drops", ndrops, 0);
        enter_raw = 1'b0; leave_raw = 1'b0;
        cyc(12);

        // Four clean exit pulses.
        t0 = edge_no; nsteps = 0; ndrops = 0;
        repeat (4) begin
            leave_raw = 1'b1;
            cyc(6);
            leave_raw = 1'b0;
            cyc(6);
        end
        cyc(10);
        chk("t4_steps", nsteps, 4);
        chk("t4_drops", ndrops, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_ud", log_ud[i], 0);
            chk("t4_edge", log_rel[i], 7 + 12 * i);
        end

        // Reset one edge before the expected step.
        enter_raw = 1'b1; t0 = edge_no; nsteps = 0;
        cyc(6);
        reset = 1'b1;
        #1;
        chk("t5_rst_step", int'(step), 0);
        chk("t5_rst_ud", int'(updown), 0);
        chk("t5_rst_drop", int'(ev_drop), 0);
        cyc(1);
        chk("t5_nostep", nsteps, 0);
        reset = 1'b0; t0 = edge_no; nsteps = 0;
        cyc(8);
        chk("t5_step_hi", int'(step), 1);
        chk("t5_edge", log_rel[0], 7);
        // Reset while step is high drops it at once.
        reset = 1'b1;
        #1;
        chk("t5_step_drop", int'(step), 0);
        cyc(1);
        reset = 1'b0; t0 = edge_no; nsteps = 0;
        cyc(20);
        chk("t5b_steps", nsteps, 1);
        chk("t5b_edge", log_rel[0], 7);
        chk("t5b_ud", log_ud[0], 1);
        enter_raw = 1'b0;
        cyc(12);

`ifdef QSF_STATS_EN
        // Wrap of the arrivals counter.
        force dut.arrivals = 16'hFFFF;
        exp_arr = 16'hFFFF;
        cyc(1);
        release dut.arrivals;
        chk("t6_preset", int'(arrivals), 16'hFFFF);
        enter_raw = 1'b1;
        cyc(20);
        chk("t6_wrap", int'(arrivals), 0);
        enter_raw = 1'b0;
        cyc(12);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/queue_sensor_frontend.md
# queue_sensor_frontend

Upstream conditioning stage for the bank queue people counter. Samples two asynchronous door sensors (entrance, exit to teller), synchronizes and debounces each, and converts each accepted rising edge into one serialized counter command: a single-cycle `step` pulse plus an `updown` direction level. It feeds the up/down customer counter directly and replaces the bare single-flop debounce in front of it.

## Interface
- `DEBOUNCE_CYCLES`, 1000000: consecutive cycles a synchronized input must differ from its filtered state before the change is accepted; range 2 to 2^DB_W−1.
- `DB_W`, 20: debounce counter width.
- `clk` in 1: system clock, all state on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enter_raw` in 1: entrance sensor, asynchronous, 1 = beam broken.
- `leave_raw` in 1: exit sensor, asynchronous, 1 = beam broken.
- `step` out 1: one-cycle command pulse to the counter.
- `updown` out 1: 1 = increment, 0 = decrement; valid while `step` is high and held until the next command.
- `ev_drop` out 1: one-cycle pulse when an accepted edge is lost because its channel already has a pending event.
- `arrivals` out 16: total accepted entrance events; present only with `QSF_STATS_EN`.

## Operation
- Per channel: 2-flop synchronizer giving `s`, then filter state `db` with counter `cnt`.
  - `s == db`: `cnt` ← 0.
  - `s != db` and `cnt == DEBOUNCE_CYCLES−1`: `db` ← `s`, `cnt` ← 0.
  - Otherwise `cnt` ← `cnt + 1`.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles never changes `db`.
- Rising edge of `db` (`db & ~db_q`) raises the channel request. The request sets `pend_up` (entrance) or `pend_down` (exit). Falling edges are ignored.
- Request while its pend flag is already set and not being cleared this cycle: flag stays set, `ev_drop` pulses.
- Request in the same cycle the FSM clears that flag: set wins, no drop.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: if `pend_up`, assert `step`, set `updown`=1, clear `pend_up`, go to PULSE. Else if `pend_down`, assert `step`, set `updown`=0, clear `pend_down`, go to PULSE. Else stay in IDLE.
  - PULSE: deassert `step`, go to GAP.
  - GAP: go to IDLE.
- Simultaneous entrance and exit: both commands are issued, up first, down 3 cycles later. There is no cancellation.
- The block does not track occupancy. Saturation at full or empty is the counter's job.

## Timing
- `step` and `updown` are registered outputs; `ev_drop` is registered.
- Latency: with the input stable and the FSM idle, `enter_raw` first sampled high at edge 0 gives `db` = 1 after edge `DEBOUNCE_CYCLES+1`, the pend flag set after edge `DEBOUNCE_CYCLES+2`, and `step` high after edge `DEBOUNCE_CYCLES+3`.
- `step` is high for exactly 1 cycle. Rising edges of `step` are at least 3 cycles apart.
- `updown` changes only on the edge that raises `step`.
- Reset values: `step`=0, `updown`=0, `ev_drop`=0, `arrivals`=0, `db`=0, `cnt`=0, sync flops 0, pend flags 0, FSM IDLE.
- Reset asserted mid-operation drops `step` immediately and discards pending events.
- After reset release, a sensor already held high is accepted as a new edge after the normal latency.
- `cnt` never exceeds `DEBOUNCE_CYCLES−1`, so no wrap occurs.

## Configuration
- `QSF_STATS_EN` defined: the `arrivals` port exists. A 16-bit counter increments by 1 on each issued `updown`=1 command, in the same edge that raises `step`, and wraps from 0xFFFF to 0x0000. Dropped events are not counted.
- `QSF_STATS_EN` undefined: the `arrivals` port and its counter are absent. All other behaviour is identical.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4.
- Reset, then `enter_raw` high from edge 0 and held: exactly one `step` after edge 7 with `updown`=1; no further `step` while held.
- `enter_raw` high for 3 cycles, then low: no `step`, no `ev_drop`.
- `enter_raw` and `leave_raw` rise in the same cycle and are held: `step` with `updown`=1 after edge 7, then `step` with `updown`=0 after edge 10.
- Four clean `leave_raw` pulses, each 6 high / 6 low: four `step` pulses with `updown`=0; `ev_drop` never asserts.
- Assert `reset` for 1 cycle one edge before an expected `step`: no `step`; outputs 0 during reset; the held sensor yields a `step` 7 edges after release.
- With `QSF_STATS_EN`, preset `arrivals` to 0xFFFF via 65535 events (or force), then one entrance event: `arrivals` becomes 0x0000.
